// File: rtl/sync_fifo_ram_if.sv
// Handshake bundle between a producer/consumer pair and sync_fifo_ram.
// Widths follow the FIFO's DATA_W and DEPTH parameters.
interface sync_fifo_ram_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              almost_full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, almost_full, empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, almost_full, empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ram.sv
// Single-clock FIFO on an inferred simple dual-port RAM with registered read port,
// occupancy counter, registered status flags and overflow/underflow pulses.
module sync_fifo_ram #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AFULL_LVL = 6
) (
    input  logic           clk,
    input  logic           rst,
    sync_fifo_ram_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rd_acc_c;
    logic              wr_acc_c;
    logic [CNT_W-1:0]  cnt_nxt_c;

    // Accept decisions use the registered flags; a full FIFO still takes a write paired with a read.
    always_comb begin
        rd_acc_c  = bus.rd_en & ~bus.empty;
        wr_acc_c  = bus.wr_en & (~bus.full | bus.rd_en);
        cnt_nxt_c = bus.count;
        if (wr_acc_c && !rd_acc_c) begin
            cnt_nxt_c = bus.count + CNT_W'(1);
        end else if (rd_acc_c && !wr_acc_c) begin
            cnt_nxt_c = bus.count - CNT_W'(1);
        end
    end

    // Storage is not reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc_c) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            bus.count       <= '0;
            bus.empty       <= 1'b1;
            bus.full        <= 1'b0;
            bus.almost_full <= 1'b0;
            bus.rd_data     <= '0;
            bus.rd_valid    <= 1'b0;
            bus.overflow    <= 1'b0;
            bus.underflow   <= 1'b0;
        end else begin
            if (wr_acc_c) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            // Old word wins on a same-address collision since mem updates non-blocking.
            if (rd_acc_c) begin
                bus.rd_data <= mem[rd_ptr];
                rd_ptr      <= rd_ptr + ADDR_W'(1);
            end
            bus.rd_valid    <= rd_acc_c;
            bus.count       <= cnt_nxt_c;
            bus.empty       <= (cnt_nxt_c == '0);
            bus.full        <= (cnt_nxt_c == CNT_W'(DEPTH));
            bus.almost_full <= (cnt_nxt_c >= CNT_W'(AFULL_LVL));
            bus.overflow    <= bus.wr_en & ~wr_acc_c;
            bus.underflow   <= bus.rd_en & ~rd_acc_c;
        end
    end
endmodule

// File: tb/tb_sync_fifo_ram.sv
// Directed bench for sync_fifo_ram: fill, drain, boundary errors, simultaneous
// access at full/empty, wrap-around against a queue model, and mid-run reset.
module tb_sync_fifo_ram;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 8;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    logic [15:0] q[$];
    logic [15:0] exp_word;
    logic [15:0] beef_seq [8];

    sync_fifo_ram_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    sync_fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_LVL(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic w, input logic [15:0] d, input logic r, input logic rs);
        bus.wr_en   = w;
        bus.wr_data = d;
        bus.rd_en   = r;
        rst         = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input int n);
        chk({tag, "_count"}, 32'(bus.count), 32'(n));
        chk({tag, "_empty"}, 32'(bus.empty), 32'(n == 0));
        chk({tag, "_full"},  32'(bus.full),  32'(n == 8));
        chk({tag, "_afull"}, 32'(bus.almost_full), 32'(n >= 6));
    endtask

    initial begin
        beef_seq = '{16'h0010, 16'h0011, 16'h0012, 16'h0013,
                     16'h0014, 16'h0015, 16'h0016, 16'hBEEF};

        // Reset state
        step(1'b0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        chk_flags("reset", 0);
        chk("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("reset_rd_data", 32'(bus.rd_data), 32'd0);
        chk("reset_overflow", 32'(bus.overflow), 32'd0);
        chk("reset_underflow", 32'(bus.underflow), 32'd0);

        // Fill 0x0001..0x0008
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 16'(i), 1'b0, 1'b0);
            chk_flags("fill", i);
        end

        // Overflow: write when full without a read
        step(1'b1, 16'hAAAA, 1'b0, 1'b0);
        chk("ovf_pulse", 32'(bus.overflow), 32'd1);
        chk_flags("ovf", 8);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        chk("ovf_clear", 32'(bus.overflow), 32'd0);

        // Drain in order; the rejected 0xAAAA must never appear
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 16'h0, 1'b1, 1'b0);
            chk("drain_valid", 32'(bus.rd_valid), 32'd1);
            chk("drain_data", 32'(bus.rd_data), 32'(i));
            chk_flags("drain", 8 - i);
        end
        step(1'b0, 16'h0, 1'b0, 1'b0);
        chk("idle_valid", 32'(bus.rd_valid), 32'd0);
        chk("idle_hold", 32'(bus.rd_data), 32'h0008);

        // Underflow: read when empty
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("udf_pulse", 32'(bus.underflow), 32'd1);
        chk("udf_valid", 32'(bus.rd_valid), 32'd0);
        chk_flags("udf", 0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        chk("udf_clear", 32'(bus.underflow), 32'd0);

        // Empty + write + read: write taken, read rejected
        step(1'b1, 16'h0055, 1'b1, 1'b0);
        chk("ewr_underflow", 32'(bus.underflow), 32'd1);
        chk("ewr_valid", 32'(bus.rd_valid), 32'd0);
        chk_flags("ewr", 1);

        // Refill to full; pointers now coincide
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 16'(16'h0010 + i), 1'b0, 1'b0);
        end
        chk_flags("refill", 8);

        // Full + write + read at same address: old head returned
        step(1'b1, 16'hBEEF, 1'b1, 1'b0);
        chk("fwr_valid", 32'(bus.rd_valid), 32'd1);
        chk("fwr_data", 32'(bus.rd_data), 32'h0055);
        chk("fwr_overflow", 32'(bus.overflow), 32'd0);
        chk_flags("fwr", 8);

        for (int i = 0; i < 8; i++) begin
            step(1'b0, 16'h0, 1'b1, 1'b0);
            chk("beef_valid", 32'(bus.rd_valid), 32'd1);
            chk("beef_data", 32'(bus.rd_data), 32'(beef_seq[i]));
        end
        chk_flags("beef_end", 0);

        // Wrap-around with reference queue
        for (int i = 0; i < 20; i++) begin
            logic do_push;
            logic [15:0] d;
            d = 16'($urandom);
            if (q.size() == 0)          do_push = 1'b1;
            else if (q.size() == DEPTH) do_push = 1'b0;
            else                        do_push = 1'($urandom_range(1, 0));
            if (do_push) begin
                q.push_back(d);
                step(1'b1, d, 1'b0, 1'b0);
                chk("wrap_push_valid", 32'(bus.rd_valid), 32'd0);
            end else begin
                exp_word = q.pop_front();
                step(1'b0, 16'h0, 1'b1, 1'b0);
                chk("wrap_pop_valid", 32'(bus.rd_valid), 32'd1);
                chk("wrap_pop_data", 32'(bus.rd_data), 32'(exp_word));
            end
            chk_flags("wrap", q.size());
        end
        while (q.size() > 0) begin
            exp_word = q.pop_front();
            step(1'b0, 16'h0, 1'b1, 1'b0);
            chk("wrap_drain_data", 32'(bus.rd_data), 32'(exp_word));
        end
        chk_flags("wrap_end", 0);

        // Reset mid-operation with a read pending
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
        end
        chk_flags("pre_rst", 5);
        step(1'b0, 16'h0, 1'b1, 1'b1);
        chk_flags("mid_rst", 0);
        chk("mid_rst_valid", 32'(bus.rd_valid), 32'd0);
        chk("mid_rst_data", 32'(bus.rd_data), 32'd0);
        step(1'b1, 16'h1234, 1'b0, 1'b0);
        chk_flags("post_rst_wr", 1);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("post_rst_valid", 32'(bus.rd_valid), 32'd1);
        chk("post_rst_data", 32'(bus.rd_data), 32'h1234);
        chk_flags("post_rst_rd", 0);
        step(1'b0, 16'h0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
